frame_loader: RTL and testbench

Pixel assembler and double-buffer write controller directly downstream of the SPI slave byte receiver. Packs the received byte stream (R, G, B per pixel, 24-bit colour) into pixel words, writes them sequentially into the back bank of a two-bank framebuffer RAM, and flips banks when a complete frame has been received. Incomplete, misaligned or oversize frames are discarded: the front bank is left untouched and `err` is pulsed.

---
 rtl/frame_loader.sv | 207 ++++++++++++++++++++
 tb/tb_frame_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_loader.sv
// frame_loader
//
// Packs the byte stream from the SPI slave receiver into 24-bit {R,G,B}
// pixels and writes them sequentially into the back bank of a two-bank
// framebuffer. When a transfer ends with exactly WIDTH*HEIGHT pixels, the
// banks flip. A frame that is short, misaligned or oversize is discarded.
// In that case the front bank is left alone and err pulses.
//
// Handshake: the input side has no back-pressure. A byte is consumed on
// every rising clk edge where valid is high. sot qualifies the first byte
// of a transfer and is only meaningful together with valid. eot is a level
// signal that is high between transfers. When eot and valid are high in the
// same cycle, eot takes priority and the byte is dropped. wr_en is a
// single-cycle strobe that qualifies wr_bank/wr_addr/wr_data. The
// framebuffer must accept a write on every cycle.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   data, valid       received byte and its one-cycle strobe
//   sot, eot          start-of-transfer flag, end-of-transfer level
//   wr_en, wr_bank,
//   wr_addr, wr_data  framebuffer write port (registered)
//   front             bank currently displayed
//   flip              one-cycle pulse when front toggles
//   err               one-cycle pulse when a frame is discarded
//   busy              high while the FSM is not IDLE
//   state_dbg         current FSM state (0=IDLE, 1=RECV, 2=DROP)

module frame_loader #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 32,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data,
  input  logic              valid,
  input  logic              sot,
  input  logic              eot,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              front,
  output logic              flip,
  output logic              err,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int PIXELS = WIDTH * HEIGHT;
  // index carries one extra bit so that it can hold the full-frame count PIXELS.
  localparam logic [ADDR_W:0] PIX_CNT = (ADDR_W + 1)'(PIXELS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [ADDR_W:0]   index_q, index_d;
  logic [7:0]        r_q, r_d;
  logic [7:0]        g_q, g_d;
  logic              front_q, front_d;
  logic              wr_bank_q, wr_bank_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]       wr_data_q, wr_data_d;
  logic              flip_q, flip_d;
  logic              err_q, err_d;

  // A new transfer may start only while slave select is active, because eot wins.
  logic start;
  assign start = valid && sot && !eot;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    index_d   = index_q;
    r_d       = r_q;
    g_d       = g_q;
    front_d   = front_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    flip_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Bytes without sot are stray and are ignored silently.
        if (start) begin
          state_d = S_RECV;
          r_d     = data;
          phase_d = 2'd1;
          index_d = '0;
        end
      end

      S_RECV: begin
        if (eot) begin
          state_d = S_IDLE;
          if (index_q == PIX_CNT && phase_q == 2'd0) begin
            front_d = ~front_q;
            flip_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (start) begin
          // The previous transfer never saw eot. Discard it and restart.
          err_d   = 1'b1;
          state_d = S_RECV;
          r_d     = data;
          phase_d = 2'd1;
          index_d = '0;
        end else if (valid) begin
          if (phase_q == 2'd0 && index_q == PIX_CNT) begin
            // First byte beyond a full frame: the frame is oversize.
            state_d = S_DROP;
          end else begin
            unique case (phase_q)
              2'd0: begin
                r_d     = data;
                phase_d = 2'd1;
              end
              2'd1: begin
                g_d     = data;
                phase_d = 2'd2;
              end
              default: begin
                wr_en_d   = 1'b1;
                wr_addr_d = index_q[ADDR_W-1:0];
                wr_data_d = {r_q, g_q, data};
                index_d   = index_q + 1'b1;
                phase_d   = 2'd0;
              end
            endcase
          end
        end
      end

      S_DROP: begin
        if (eot) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (start) begin
          err_d   = 1'b1;
          state_d = S_RECV;
          r_d     = data;
          phase_d = 2'd1;
          index_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The write bank is always the one that is not displayed.
  // It follows front in the same cycle that front changes.
  assign wr_bank_d = ~front_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= 2'd0;
      index_q   <= '0;
      r_q       <= 8'd0;
      g_q       <= 8'd0;
      front_q   <= 1'b0;
      wr_bank_q <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 24'd0;
      flip_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      index_q   <= index_d;
      r_q       <= r_d;
      g_q       <= g_d;
      front_q   <= front_d;
      wr_bank_q <= wr_bank_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      flip_q    <= flip_d;
      err_q     <= err_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_bank   = wr_bank_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign front     = front_q;
  assign flip      = flip_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_frame_loader.sv
// Directed testbench for frame_loader with WIDTH=4, HEIGHT=2 (8 pixels).

module tb_frame_loader;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int ADDR_W = 3;
  localparam int PIXELS = WIDTH * HEIGHT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]        data  = 8'd0;
  logic              valid = 1'b0;
  logic              sot   = 1'b0;
  logic              eot   = 1'b1;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              front;
  logic              flip;
  logic              err;
  logic              busy;
  logic [1:0]        state_dbg;

  frame_loader #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .valid    (valid),
    .sot      (sot),
    .eot      (eot),
    .wr_en    (wr_en),
    .wr_bank  (wr_bank),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .front    (front),
    .flip     (flip),
    .err      (err),
    .busy     (busy),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  localparam int EW = 1 + ADDR_W + 24;
  logic [EW-1:0] exp_q[$];

  int checks     = 0;
  int errors     = 0;
  int flip_cnt   = 0;
  int err_cnt    = 0;
  int total_flip = 0;
  int lat_bad    = 0;
  int busy_low   = 0;
  logic exp_front = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: each write is compared against the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      check("wr_bank_is_not_front", {63'd0, wr_bank}, {63'd0, ~front});
      if (wr_en) begin
        logic [EW-1:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {EW{1'bx}};
        check("write", {36'd0, wr_bank, wr_addr, wr_data}, {36'd0, e});
      end
      if (flip) begin
        flip_cnt++;
        total_flip++;
        check("last_write_before_flip", {63'd0, wr_en}, 64'd0);
      end
      if (err) err_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  // Sends n bytes (byte i has value i, sot on byte 0) back-to-back without
  // raising eot. Queues the writes expected for every complete pixel.
  task automatic send_bytes(input int n);
    for (int p = 0; p < PIXELS && 3 * p + 2 < n; p++) begin
      logic [EW-1:0] e;
      e = {~exp_front, ADDR_W'(p), 8'(3 * p), 8'(3 * p + 1), 8'(3 * p + 2)};
      exp_q.push_back(e);
    end
    lat_bad  = 0;
    busy_low = 0;
    @(negedge clk);
    eot = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        // Byte i-1 was sampled on the last edge; B bytes of pixels 0..7
        // must show up as a write one cycle later.
        if (wr_en !== ((i % 3 == 0) && (i <= 3 * PIXELS))) lat_bad++;
        if (!busy) busy_low++;
      end
      if (i < n) begin
        data  = 8'(i);
        valid = 1'b1;
        sot   = (i == 0);
        @(negedge clk);
      end else begin
        valid = 1'b0;
        sot   = 1'b0;
      end
    end
    check("write_latency", 64'(lat_bad), 64'd0);
    check("busy_during_transfer", 64'(busy_low), 64'd0);
  endtask

  // Raises eot and checks the pulse on the following cycle and the totals.
  task automatic end_frame(input string tag, input bit ok, input int exp_errs);
    eot = 1'b1;
    @(negedge clk);
    if (ok) exp_front = ~exp_front;
    check({tag, "_flip_pulse"}, {63'd0, flip}, {63'd0, ok});
    check({tag, "_err_pulse"}, {63'd0, err}, {63'd0, !ok});
    check({tag, "_front"}, {63'd0, front}, {63'd0, exp_front});
    repeat (3) @(negedge clk);
    check({tag, "_flip_count"}, 64'(flip_cnt), 64'(ok));
    check({tag, "_err_count"}, 64'(err_cnt), 64'(exp_errs));
    check({tag, "_writes_outstanding"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_busy_idle"}, {63'd0, busy}, 64'd0);
    flip_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, {63'd0, wr_en}, 64'd0);
    check({tag, "_wr_bank"}, {63'd0, wr_bank}, 64'd1);
    check({tag, "_wr_addr"}, {61'd0, wr_addr}, 64'd0);
    check({tag, "_wr_data"}, {40'd0, wr_data}, 64'd0);
    check({tag, "_front"}, {63'd0, front}, 64'd0);
    check({tag, "_flip"}, {63'd0, flip}, 64'd0);
    check({tag, "_err"}, {63'd0, err}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_state"}, {62'd0, state_dbg}, 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // A stray byte without sot while idle is ignored.
    data  = 8'hAA;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    check("stray_byte_busy", {63'd0, busy}, 64'd0);
    check("stray_byte_err", 64'(err_cnt), 64'd0);

    // Full frame: writes bank 1, then flips to front=1.
    send_bytes(24);
    end_frame("full1", 1'b1, 0);

    // Second full frame: writes bank 0, front back to 0.
    send_bytes(24);
    end_frame("full2", 1'b1, 0);
    check("two_flips_total", 64'(total_flip), 64'd2);

    // Short frame: 7 pixels.
    send_bytes(21);
    end_frame("short", 1'b0, 1);

    // Misaligned frame: 7 pixels plus two stray colour bytes.
    send_bytes(23);
    end_frame("misaligned", 1'b0, 1);

    // Oversize frame: extra bytes are dropped while busy stays high.
    send_bytes(27);
    check("overflow_state_drop", {62'd0, state_dbg}, 64'd2);
    end_frame("overflow", 1'b0, 1);

    // Missing eot: a new sot restarts the frame, and the old one errors.
    send_bytes(6);
    send_bytes(24);
    end_frame("restart", 1'b1, 1);

    // Reset in the middle of a frame while front=1.
    check("pre_reset_front", {63'd0, front}, 64'd1);
    send_bytes(10);
    rst = 1'b1;
    eot = 1'b1;
    #1;
    check_reset_outputs("midreset");
    check("midreset_writes_outstanding", 64'(exp_q.size()), 64'd0);
    exp_front = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_no_err", 64'(err_cnt), 64'd0);
    check("midreset_no_flip", 64'(flip_cnt), 64'd0);

    // Frame after reset flips normally.
    send_bytes(24);
    end_frame("after_reset", 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
